// File: rtl/async_fifo_wr_arbiter.sv
// Round-robin arbiter sharing one async-FIFO write port between NUM_REQ requesters.
// Define ASYNC_FIFO_ARB_BURST_LOCK_EN to hold a grant for up to MAX_BURST beats.
module async_fifo_wr_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MAX_BURST  = 4
) (
    input  logic                            wclk,
    input  logic                            wrst,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
    input  logic                            wfull,
    output logic [NUM_REQ-1:0]              gnt,
    output logic                            winc,
    output logic [DATA_WIDTH-1:0]           wdata,
    output logic                            busy,
    output logic                            stall
);

    localparam int unsigned      IDX_W    = $clog2(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);
    localparam logic             ST_IDLE  = 1'b0;
    localparam logic             ST_LOCK  = 1'b1;

    logic [IDX_W-1:0]      r_last;
    logic [IDX_W-1:0]      w_last_nxt;
    logic                  w_state;
    logic [IDX_W-1:0]      w_cand;
    logic [IDX_W-1:0]      w_scan_idx;
    logic                  w_scan_vld;
    logic [IDX_W-1:0]      w_win_idx;
    logic                  w_win_vld;
    logic                  w_grant_en;
    logic [DATA_WIDTH-1:0] w_data_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_data
        assign w_data_arr[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // Nearest set request after r_last wins; scanning far-to-near lets the last hit take priority.
    always_comb begin
        w_cand     = '0;
        w_scan_idx = '0;
        w_scan_vld = 1'b0;
        for (int unsigned k = NUM_REQ; k >= 1; k--) begin
            w_cand = IDX_W'((32'(r_last) + k) % NUM_REQ);
            if (req[w_cand]) begin
                w_scan_vld = 1'b1;
                w_scan_idx = w_cand;
            end
        end
    end

    always_comb begin
        w_win_idx  = (w_state == ST_LOCK) ? r_last : w_scan_idx;
        w_win_vld  = (w_state == ST_LOCK) ? req[r_last] : w_scan_vld;
        w_grant_en = w_win_vld && !wfull && !wrst;
        gnt        = w_grant_en ? (NUM_REQ'(1) << w_win_idx) : '0;
        winc       = w_grant_en;
        wdata      = w_grant_en ? w_data_arr[w_win_idx] : '0;
        stall      = (|req) && wfull && !wrst;
        busy       = (w_state == ST_LOCK);
    end

`ifdef ASYNC_FIFO_ARB_BURST_LOCK_EN
    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

    logic             r_state;
    logic             w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    assign w_state = r_state;

    // A dropped request ends the lock even when the FIFO is also full; stalled cycles are not counted.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_last_nxt  = r_last;
        case (r_state)
            ST_IDLE: begin
                if (winc) begin
                    w_last_nxt = w_win_idx;
                    if (MAX_BURST > 1) begin
                        w_state_nxt = ST_LOCK;
                        w_cnt_nxt   = CNT_W'(1);
                    end
                end
            end
            ST_LOCK: begin
                if (!req[r_last]) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else if (winc) begin
                    if ((32'(r_cnt) + 32'd1) == MAX_BURST) begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_last  <= LAST_RST;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_last  <= w_last_nxt;
        end
    end
`else
    assign w_state    = ST_IDLE;
    assign w_last_nxt = winc ? w_win_idx : r_last;

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            r_last <= LAST_RST;
        end else begin
            r_last <= w_last_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_async_fifo_wr_arbiter.sv
// Vector-table bench for async_fifo_wr_arbiter; covers both burst-lock builds.
module tb_async_fifo_wr_arbiter;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       wf;
        logic [3:0] gnt;
        logic       winc;
        logic [7:0] wdata;
        logic       busy;
        logic       stall;
    } vec_t;

    logic        wclk = 1'b0;
    logic        wrst = 1'b1;
    logic [3:0]  req  = '0;
    logic [31:0] req_data = 32'h44332211;
    logic        wfull = 1'b0;
    logic [3:0]  gnt;
    logic        winc;
    logic [7:0]  wdata;
    logic        busy;
    logic        stall;

    int total = 0;
    int bad   = 0;
    vec_t vecs[$];
    vec_t exp_q[$];

    async_fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(4)) dut (
        .wclk(wclk), .wrst(wrst), .req(req), .req_data(req_data), .wfull(wfull),
        .gnt(gnt), .winc(winc), .wdata(wdata), .busy(busy), .stall(stall)
    );

    always #5 wclk = ~wclk;

    function automatic void add(input logic r, input logic [3:0] rq, input logic wf,
                                input logic [3:0] g, input logic wi, input logic [7:0] wd,
                                input logic b, input logic s);
        vec_t v;
        v.rst = r; v.req = rq; v.wf = wf; v.gnt = g; v.winc = wi;
        v.wdata = wd; v.busy = b; v.stall = s;
        vecs.push_back(v);
    endfunction

    task automatic cmp(input string nm, input int idx, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s step=%0d got=%0h exp=%0h", nm, idx, got, exp);
        end
    endtask

    // Pop the expectation queued with the stimulus and compare against the settled outputs.
    task automatic sample(input int idx);
        vec_t e;
        if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL scoreboard_empty step=%0d got=0 exp=1", idx);
        end else begin
            e = exp_q.pop_front();
            cmp("gnt",   idx, 8'(gnt),   8'(e.gnt));
            cmp("winc",  idx, 8'(winc),  8'(e.winc));
            cmp("wdata", idx, wdata,     e.wdata);
            cmp("busy",  idx, 8'(busy),  8'(e.busy));
            cmp("stall", idx, 8'(stall), 8'(e.stall));
        end
    endtask

    task automatic apply(input int idx, input vec_t v);
        @(negedge wclk);
        wrst  = v.rst;
        req   = v.req;
        wfull = v.wf;
        exp_q.push_back(v);
        #1;
        sample(idx);
    endtask

    task automatic expect_now(input int idx, input logic [3:0] g, input logic wi,
                              input logic [7:0] wd, input logic b, input logic s);
        vec_t v;
        v.rst = wrst; v.req = req; v.wf = wfull; v.gnt = g; v.winc = wi;
        v.wdata = wd; v.busy = b; v.stall = s;
        exp_q.push_back(v);
        #1;
        sample(idx);
    endtask

    initial begin
        //  rst  req     wf    gnt     winc  wdata  busy  stall
        add(1, 4'b1111, 0, 4'b0000, 0, 8'h00, 0, 0);
        add(1, 4'b1111, 0, 4'b0000, 0, 8'h00, 0, 0);
`ifdef ASYNC_FIFO_ARB_BURST_LOCK_EN
        add(0, 4'b0011, 0, 4'b0001, 1, 8'h11, 0, 0);
        add(0, 4'b0011, 0, 4'b0001, 1, 8'h11, 1, 0);
        add(0, 4'b0011, 0, 4'b0001, 1, 8'h11, 1, 0);
        add(0, 4'b0011, 0, 4'b0001, 1, 8'h11, 1, 0);
        add(0, 4'b0011, 0, 4'b0010, 1, 8'h22, 0, 0);
        add(0, 4'b0011, 0, 4'b0010, 1, 8'h22, 1, 0);
        add(0, 4'b0011, 0, 4'b0010, 1, 8'h22, 1, 0);
        add(0, 4'b0011, 0, 4'b0010, 1, 8'h22, 1, 0);
        add(0, 4'b0011, 0, 4'b0001, 1, 8'h11, 0, 0);
        add(0, 4'b0011, 0, 4'b0001, 1, 8'h11, 1, 0);
        add(0, 4'b0010, 0, 4'b0000, 0, 8'h00, 1, 0);
        add(0, 4'b0010, 0, 4'b0010, 1, 8'h22, 0, 0);
        add(0, 4'b0010, 0, 4'b0010, 1, 8'h22, 1, 0);
        add(0, 4'b0011, 1, 4'b0000, 0, 8'h00, 1, 1);
        add(0, 4'b0011, 0, 4'b0010, 1, 8'h22, 1, 0);
        add(0, 4'b0011, 0, 4'b0010, 1, 8'h22, 1, 0);
        add(0, 4'b0011, 0, 4'b0001, 1, 8'h11, 0, 0);
        add(0, 4'b0010, 1, 4'b0000, 0, 8'h00, 1, 1);
        add(0, 4'b0010, 0, 4'b0010, 1, 8'h22, 0, 0);
`else
        add(0, 4'b1111, 0, 4'b0001, 1, 8'h11, 0, 0);
        add(0, 4'b1111, 0, 4'b0010, 1, 8'h22, 0, 0);
        add(0, 4'b1111, 0, 4'b0100, 1, 8'h33, 0, 0);
        add(0, 4'b1111, 0, 4'b1000, 1, 8'h44, 0, 0);
        add(0, 4'b1111, 0, 4'b0001, 1, 8'h11, 0, 0);
        add(0, 4'b0100, 1, 4'b0000, 0, 8'h00, 0, 1);
        add(0, 4'b0100, 1, 4'b0000, 0, 8'h00, 0, 1);
        add(0, 4'b0100, 1, 4'b0000, 0, 8'h00, 0, 1);
        add(0, 4'b0100, 0, 4'b0100, 1, 8'h33, 0, 0);
        add(0, 4'b0000, 0, 4'b0000, 0, 8'h00, 0, 0);
        add(0, 4'b0000, 1, 4'b0000, 0, 8'h00, 0, 0);
        add(0, 4'b1011, 0, 4'b1000, 1, 8'h44, 0, 0);
        add(0, 4'b1011, 0, 4'b0001, 1, 8'h11, 0, 0);
        add(0, 4'b0010, 0, 4'b0010, 1, 8'h22, 0, 0);
        add(0, 4'b0001, 0, 4'b0001, 1, 8'h11, 0, 0);
`endif
        foreach (vecs[i]) apply(i, vecs[i]);

        // Asynchronous reset in the middle of a cycle, then arbitration restarts at requester 0.
        @(negedge wclk);
        req   = 4'b1111;
        wfull = 1'b0;
`ifdef ASYNC_FIFO_ARB_BURST_LOCK_EN
        expect_now(100, 4'b0010, 1, 8'h22, 1, 0);
`else
        expect_now(100, 4'b0010, 1, 8'h22, 0, 0);
`endif
        #1 wrst = 1'b1;
        expect_now(101, 4'b0000, 0, 8'h00, 0, 0);
        wfull = 1'b1;
        expect_now(102, 4'b0000, 0, 8'h00, 0, 0);
        @(negedge wclk);
        wrst  = 1'b0;
        wfull = 1'b0;
        expect_now(103, 4'b0001, 1, 8'h11, 0, 0);

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
